// File: rtl/apu_i2s_out_if.sv
// -----------------------------------------------------------------------------
// apu_i2s_out_if
//
// Signal bundle between the APU mixer side and the I2S output stage.
//
//   enable_i      stream enable; low holds the serializer idle
//   sample_i      16-bit unsigned (offset-binary) mixed level from the APU
//   gain_i        unsigned Q4.4 gain, 0x10 = unity
//   mute_i        forces the transmitted sample to 0x0000
//   sample_stb_o  one-clk pulse when sample_i is captured
//   bclk_o        I2S bit clock
//   lrclk_o       I2S word select (0 = left, 1 = right)
//   sdata_o       I2S serial data, MSB first
//
// The slave modport is the output stage itself; the master modport is
// whatever drives it (mixer or testbench).
// -----------------------------------------------------------------------------
interface apu_i2s_out_if;
  logic        enable_i;
  logic [15:0] sample_i;
  logic [7:0]  gain_i;
  logic        mute_i;
  logic        sample_stb_o;
  logic        bclk_o;
  logic        lrclk_o;
  logic        sdata_o;

  modport master (
    output enable_i,
    output sample_i,
    output gain_i,
    output mute_i,
    input  sample_stb_o,
    input  bclk_o,
    input  lrclk_o,
    input  sdata_o
  );

  modport slave (
    input  enable_i,
    input  sample_i,
    input  gain_i,
    input  mute_i,
    output sample_stb_o,
    output bclk_o,
    output lrclk_o,
    output sdata_o
  );
endinterface : apu_i2s_out_if

// File: rtl/apu_i2s_out.sv
// -----------------------------------------------------------------------------
// apu_i2s_out
//
// Output stage behind the APU mixer. Once per audio frame it captures the
// unsigned mixed level, converts it to two's complement, applies a Q4.4 gain
// with saturation and transmits it as a Philips I2S stream, the same word on
// the left and right channel. BCLK and LRCLK are derived from clk_i.
//
// Ports:
//   clk_i    system clock
//   reset_i  asynchronous reset, active-high; clears every flop
//   bus      apu_i2s_out_if.slave (enable, sample, gain, mute in;
//            sample strobe, bclk, lrclk, sdata out)
//
// Parameter:
//   BCLK_DIV system clocks per BCLK period; even and >= 4.
//
// Timing (one frame = 32 BCLK = 32*BCLK_DIV clks):
//   fall event into slot 0  : sample captured, sample_stb_o pulses
//   capture + 3 clks        : gained/saturated word y ready
//   fall event into slot 1  : y loaded into serializer, MSB of L driven
//   fall event into slot 17 : MSB of R driven
//   fall event into slot 0  : LSB of R driven (and next capture)
// -----------------------------------------------------------------------------
module apu_i2s_out #(
  parameter int BCLK_DIV = 8
) (
  input  logic          clk_i,
  input  logic          reset_i,
  apu_i2s_out_if.slave  bus
);

  if (BCLK_DIV < 4 || (BCLK_DIV % 2) != 0) begin : g_bad_div
    $error("apu_i2s_out: BCLK_DIV must be even and >= 4");
  end

  localparam int              DIV_W    = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // Bit-clock divider and frame position
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [4:0]       slot_q,    slot_d;

  // Registered I2S outputs
  logic             bclk_q,    bclk_d;
  logic             lrclk_q,   lrclk_d;
  logic             sdata_q,   sdata_d;
  logic             stb_q,     stb_d;

  // Serializer: holds the remaining bits of {L, R}
  logic [31:0]      shreg_q,   shreg_d;

  // Sample pipeline: capture -> convert -> gain -> saturate/mute
  logic [15:0]        cap_q,   cap_d;
  logic               v1_q,    v1_d;
  logic signed [15:0] s_q,     s_d;
  logic               v2_q,    v2_d;
  logic signed [24:0] prod_q,  prod_d;
  logic [15:0]        y_q,     y_d;

  // Combinational helpers
  logic [4:0]         slot_next;
  logic signed [24:0] s_ext;
  logic signed [24:0] g_ext;
  logic signed [24:0] prod_full;

  // ---------------------------------------------------------------------------
  // Divider, slot counter, capture and serializer
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d starts from its hold value so no branch can leave one
    // unassigned and infer a latch.
    div_cnt_d = div_cnt_q;
    slot_d    = slot_q;
    bclk_d    = bclk_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    stb_d     = 1'b0;
    shreg_d   = shreg_q;
    cap_d     = cap_q;
    slot_next = slot_q + 5'd1;

    if (!bus.enable_i) begin
      // Idle: counters parked at the start of slot 0, outputs quiet. The
      // serializer keeps its contents but does not shift.
      div_cnt_d = '0;
      slot_d    = '0;
      bclk_d    = 1'b0;
      lrclk_d   = 1'b0;
      sdata_d   = 1'b0;
    end else begin
      if (div_cnt_q == DIV_LAST) begin
        // Fall event: BCLK goes low and everything slot-related advances.
        div_cnt_d = '0;
        slot_d    = slot_next;
        lrclk_d   = slot_next[4];

        if (slot_q == 5'd31) begin
          stb_d = 1'b1;
          cap_d = bus.sample_i;
        end

        if (slot_q == 5'd0) begin
          // Entering slot 1: load {y, y} and present its MSB in the same
          // event, which is the one-BCLK delay after the LRCLK edge.
          sdata_d = y_q[15];
          shreg_d = {y_q[14:0], y_q, 1'b0};
        end else begin
          sdata_d = shreg_q[31];
          shreg_d = {shreg_q[30:0], 1'b0};
        end
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end

      // Derived from the next count so bclk_o is a clean register output.
      bclk_d = (div_cnt_d >= DIV_HALF);
    end
  end

  // ---------------------------------------------------------------------------
  // Sample pipeline
  // Stages advance only behind a capture, so gain_i and mute_i are looked at
  // once per frame and a later change cannot disturb the word in flight.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_d    = s_q;
    v1_d   = stb_q;
    v2_d   = v1_q;
    prod_d = prod_q;
    y_d    = y_q;

    // Operands widened to the full product width; gain is unsigned so it is
    // zero-extended.
    s_ext     = {{9{s_q[15]}}, s_q};
    g_ext     = {17'd0, bus.gain_i};
    prod_full = s_ext * g_ext;

    // Stage 1: offset-binary to two's complement (0x8000 is silence).
    if (stb_q) begin
      s_d = {~cap_q[15], cap_q[14:0]};
    end

    // Stage 2: Q4.4 gain; arithmetic shift rounds toward -inf.
    if (v1_q) begin
      prod_d = prod_full >>> 4;
    end

    // Stage 3: clamp to 16 bits, then mute.
    if (v2_q) begin
      if (prod_q > 25'sd32767) begin
        y_d = 16'h7FFF;
      end else if (prod_q < -25'sd32768) begin
        y_d = 16'h8000;
      end else begin
        y_d = prod_q[15:0];
      end
      if (bus.mute_i) begin
        y_d = 16'h0000;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the values from before the edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      div_cnt_q <= '0;
      slot_q    <= '0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      stb_q     <= 1'b0;
      shreg_q   <= '0;
      cap_q     <= '0;
      v1_q      <= 1'b0;
      s_q       <= '0;
      v2_q      <= 1'b0;
      prod_q    <= '0;
      y_q       <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      slot_q    <= slot_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      stb_q     <= stb_d;
      shreg_q   <= shreg_d;
      cap_q     <= cap_d;
      v1_q      <= v1_d;
      s_q       <= s_d;
      v2_q      <= v2_d;
      prod_q    <= prod_d;
      y_q       <= y_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.sample_stb_o = stb_q;
  assign bus.bclk_o       = bclk_q;
  assign bus.lrclk_o      = lrclk_q;
  assign bus.sdata_o      = sdata_q;

endmodule : apu_i2s_out

// File: doc/apu_i2s_out.md
Name: apu_i2s_out

Overview:
- Output stage directly downstream of the APU mixer; consumes the APU's 16-bit unsigned mixed level (master output).
- Once per audio frame it samples the level, converts it to signed, applies a Q4.4 gain with saturation, and serializes the result as a standard Philips I2S stream (mono, duplicated to L and R) for an external DAC.
- It generates its own BCLK/LRCLK from the system clock.

Parameters:
BCLK_DIV, 8, system clocks per BCLK period; must be even and >= 4 (elaboration error otherwise).

Ports:
clk_i  input  1  system clock
reset_i  input  1  asynchronous reset, active-high
enable_i  input  1  stream enable; low holds the serializer idle
sample_i  input  16  unsigned mixed level from the APU
gain_i  input  8  unsigned Q4.4 gain; 0x10 = unity
mute_i  input  1  forces the transmitted sample to 0x0000
sample_stb_o  output  1  one-clk pulse when sample_i is captured
bclk_o  output  1  I2S bit clock
lrclk_o  output  1  I2S word select; 0 = left, 1 = right
sdata_o  output  1  I2S serial data, MSB first

Behaviour:
- Reset (async, any time including mid-frame):
  - All outputs go to 0.
  - Divider, slot counter, pipeline and 32-bit shift register clear to 0.
  - After release, operation starts at slot 0, low phase.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - bclk_o = 1 when div_cnt >= BCLK_DIV/2, else 0. It is registered and glitch-free.
  - The "fall event" is the clk where div_cnt wraps to 0.
- Slot counter:
  - slot counts 0..31, incrementing on each fall event and wrapping 31 -> 0.
  - lrclk_o = (slot >= 16), updated on the fall event.
  - Frame length = 32*BCLK_DIV clks; fs = f_clk/(32*BCLK_DIV).
- Capture:
  - On the fall event entering slot 0, sample_stb_o = 1 for exactly one clk.
  - sample_i is registered in that same clk.
- Pipeline (fixed 3-clk latency from capture; completes before slot 1 because BCLK_DIV >= 4):
  - Stage 1: s = {~sample[15], sample[14:0]} (offset-binary to two's complement, 0x8000 -> 0).
  - Stage 2: p = s * gain_i as a signed 25-bit product (gain zero-extended); q = p >>> 4 (arithmetic shift, floor toward -inf).
  - Stage 3: saturate q to [-32768, 32767]. If mute_i is high in this clk, the result is 0x0000.
  - gain_i and mute_i are sampled in stage 2 and stage 3 respectively; a change mid-frame takes effect on the next capture.
- Serializer:
  - On the fall event entering slot 1, the shift register loads {y, y} (L = R = y).
  - On every subsequent fall event, sdata_o <= shreg[31] and shreg shifts left, filling with 0.
  - This gives the standard I2S one-BCLK delay: MSB of L in slot 1, MSB of R in slot 17, LSB of R in slot 0 of the next frame.
  - sdata_o changes only on fall events, so it is stable at every bclk_o rising edge.
- Enable:
  - While enable_i = 0, bclk_o, lrclk_o, sdata_o and sample_stb_o are held at 0, and div_cnt and slot are held at 0. The shift register contents are retained but not shifted.
  - When enable_i rises, div_cnt starts from 0. The first fall event enters slot 1; the capture at slot 0 is therefore skipped for that frame, so the first frame transmits the previous y (0 after reset).
  - When enable_i falls mid-frame, the outputs go to 0 on the next clk. There is no completion of the frame.
- Wrap/overflow:
  - The only arithmetic overflow point is stage 3 saturation; no other wrap is permitted.
  - The slot counter wrap is the frame boundary.

Test Plan:
- Reset/idle: assert reset_i mid-frame with BCLK_DIV=4 -> all outputs 0 within the same clk; after release, bclk_o first rises 2 clks later, sample_stb_o pulses every 128 clks.
- Unity: sample_i=0xFFFF, gain_i=0x10 -> L and R words decoded from sdata_o at bclk_o rising edges = 0x7FFF; sample_i=0x8000 -> 0x0000; MSB appears one BCLK after each lrclk_o edge.
- Attenuation/floor: sample_i=0xC000, gain_i=0x08 -> 0x2000; sample_i=0x3FFF (s=-16385), gain_i=0x08 -> 0xDFFF (floor of -8192.5).
- Saturation: gain_i=0x20 with sample_i=0xC000 -> 0x7FFF; with sample_i=0x0000 -> 0x8000; gain_i=0x00 -> 0x0000.
- Mute and gain change: toggle mute_i and gain_i mid-frame -> the current frame is unchanged; the next frame carries 0x0000 (mute) or the new gain.
- Enable: drop enable_i at slot 10 -> outputs 0 next clk, counters held; re-raise -> the first frame carries the stale word, the second frame carries the freshly captured sample.
